// File: rtl/rv_rf_pkg.sv
// rtl/rv_rf_pkg.sv - shared register-file widths, selector/data types and grant encoding
package rv_rf_pkg;
  localparam int REG_SEL_W = 5;
  localparam int XLEN      = 32;
  localparam int NUM_REGS  = 32;

  typedef logic [REG_SEL_W-1:0] reg_sel_t;
  typedef logic [XLEN-1:0]      xlen_t;

  typedef enum logic [1:0] {
    GRANT_NONE = 2'd0,
    GRANT_0    = 2'd1,
    GRANT_1    = 2'd2
  } grant_t;
endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - pending long-latency write scoreboard with sticky protocol error
module rf_scoreboard
  import rv_rf_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     issue_en,
  input  reg_sel_t issue_sel,
  input  logic     grant0,
  input  reg_sel_t sel0,
  input  logic     grant1,
  input  reg_sel_t sel1,
  input  reg_sel_t chk1_sel,
  input  reg_sel_t chk2_sel,
  output logic     chk1_busy,
  output logic     chk2_busy,
  output logic     err
);

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_next;
  logic                err_now;

  // Set is applied after clear so a re-issue to a completing register stays busy.
  always_comb begin
    busy_next = busy;
    if (grant1) busy_next[sel1] = 1'b0;
    if (issue_en && (issue_sel != '0)) busy_next[issue_sel] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_comb begin
    err_now = 1'b0;
    if (issue_en && busy[issue_sel] && !(grant1 && (sel1 == issue_sel))) err_now = 1'b1;
    if (grant1 && (sel1 != '0) && !busy[sel1]) err_now = 1'b1;
    if (grant0 && busy[sel0]) err_now = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
      err  <= 1'b0;
    end else begin
      busy <= busy_next;
      err  <= err | err_now;
    end
  end

  assign chk1_busy = !rst && busy[chk1_sel];
  assign chk2_busy = !rst && busy[chk2_sel];

endmodule

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - register-file write-port arbiter with starvation guard and busy scoreboard
module rf_wb_arbiter
  import rv_rf_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     req0Valid,
  input  reg_sel_t req0Sel,
  input  xlen_t    req0Data,
  output logic     req0Ready,
  input  logic     req1Valid,
  input  reg_sel_t req1Sel,
  input  xlen_t    req1Data,
  output logic     req1Ready,
  input  logic     issueEn,
  input  reg_sel_t issueSel,
  input  reg_sel_t chk1Sel,
  input  reg_sel_t chk2Sel,
  output logic     chk1Busy,
  output logic     chk2Busy,
  output reg_sel_t writeRegSel,
  output xlen_t    writeData,
  output logic     writeEn,
  output logic     err
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt;
  grant_t     grant;

  // Long-latency requester wins once it has waited LIMIT cycles; otherwise pipeline first.
  always_comb begin
    grant = GRANT_NONE;
    if (!rst) begin
      if (req1Valid && (starve_cnt >= LIMIT)) grant = GRANT_1;
      else if (req0Valid)                     grant = GRANT_0;
      else if (req1Valid)                     grant = GRANT_1;
    end
  end

  always_comb begin
    writeRegSel = '0;
    writeData   = '0;
    case (grant)
      GRANT_0: begin
        writeRegSel = req0Sel;
        writeData   = req0Data;
      end
      GRANT_1: begin
        writeRegSel = req1Sel;
        writeData   = req1Data;
      end
      default: begin
        writeRegSel = '0;
        writeData   = '0;
      end
    endcase
  end

  assign req0Ready = (grant == GRANT_0);
  assign req1Ready = (grant == GRANT_1);
  assign writeEn   = (grant != GRANT_NONE) && (writeRegSel != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (!req1Valid || (grant == GRANT_1)) begin
      starve_cnt <= '0;
    end else if (starve_cnt != 4'hF) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  rf_scoreboard u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .issue_en  (issueEn),
    .issue_sel (issueSel),
    .grant0    (req0Ready),
    .sel0      (req0Sel),
    .grant1    (req1Ready),
    .sel1      (req1Sel),
    .chk1_sel  (chk1Sel),
    .chk2_sel  (chk2Sel),
    .chk1_busy (chk1Busy),
    .chk2_busy (chk2Busy),
    .err       (err)
  );

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-port arbiter and scoreboard for the 32×32 RISC-V register file. It shares the file's single write port between the in-order pipeline writeback (requester 0) and the long-latency unit writeback (requester 1, e.g. divider/load miss). It also tracks which registers have an outstanding long-latency write so decode can stall. It sits between the writeback sources and the bypassing register file, driving that file's `writeRegSel`/`writeData`/`writeEn` directly.

## Interface
Parameters:
- `STARVE_LIMIT`, default 4: consecutive cycles requester 1 may wait before it takes priority; legal range 1–15.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req0Valid`, `req0Sel`, `req0Data`  in  1, 5, 32  pipeline writeback request, destination, data.
- `req0Ready`  out  1  request 0 accepted this cycle.
- `req1Valid`, `req1Sel`, `req1Data`  in  1, 5, 32  long-latency writeback request.
- `req1Ready`  out  1  request 1 accepted this cycle.
- `issueEn`, `issueSel`  in  1, 5  long-latency op issued; mark `issueSel` busy.
- `chk1Sel`, `chk2Sel`  in  5, 5  decode source registers to check.
- `chk1Busy`, `chk2Busy`  out  1, 1  the checked register has a pending long-latency write.
- `writeRegSel`, `writeData`, `writeEn`  out  5, 32, 1  register file write port.
- `err`  out  1  sticky protocol error.

## Operation
- State:
  - `busy[31:0]` scoreboard.
  - `starveCnt` (4 bits).
  - `err` flag.
- Grant rule, evaluated each cycle:
  - If `req1Valid && starveCnt >= STARVE_LIMIT`, grant 1.
  - Else if `req0Valid`, grant 0.
  - Else if `req1Valid`, grant 1.
  - Else no grant.
- `reqNReady` = grant N; at most one ready per cycle.
- Write port is driven by the granted requester: `writeRegSel`/`writeData` = selected source.
- `writeEn` = grant exists AND granted `Sel != 0`. Writes to x0 are accepted (ready=1) but suppressed.
- With no grant: `writeEn=0`, `writeRegSel=0`, `writeData=0`.
- `starveCnt`:
  - Cleared when `req1Valid=0` or request 1 is granted.
  - Otherwise incremented, saturating at 15.
- Scoreboard, at each rising edge:
  - Set: `busy[issueSel]` set when `issueEn && issueSel != 0`.
  - Clear: `busy[req1Sel]` cleared when request 1 is granted.
  - Same register set and cleared in the same cycle: set wins (new issue replaces the completing one).
  - `busy[0]` is always 0.
- `chkNBusy` = `busy[chkNSel]` from the registered vector only; no same-cycle forwarding of set or clear.
  - The register file's own bypass covers a write landing in the same cycle.
- `err` is set (sticky until `rst`) on any of:
  - `issueEn` to a register already busy and not being cleared this cycle;
  - request 1 granted for a nonzero register whose `busy` bit is 0;
  - request 0 granted for a register whose `busy` bit is 1 (WAW ordering violation).

## Timing
- Arbitration, ready, and write port are combinational from same-cycle inputs; zero-cycle latency to `writeEn`.
- The register file captures the write at the same rising edge.
- Requesters hold `Valid`/`Sel`/`Data` stable until `Ready`; an accepted request completes at that edge.
- Scoreboard and counter update at the rising edge; effects are visible on `chkNBusy` the next cycle.
- Reset (`rst=1` at an edge):
  - `busy=0`, `starveCnt=0`, `err=0`.
  - While `rst` is high: both ready=0, `writeEn=0`, `chkNBusy=0`.
  - In-flight requests are dropped; requesters must re-present them after reset.
- `req0` asserted every cycle with `req1` waiting: `req1` is granted on the cycle where `starveCnt` reaches `STARVE_LIMIT`, i.e. its `STARVE_LIMIT+1`-th waiting cycle.

## Structure
- Shared package `rv_rf_pkg`:
  - `REG_SEL_W=5`, `XLEN=32`, `NUM_REGS=32`;
  - typedef `reg_sel_t`, typedef `xlen_t`.
- Sub-module `rf_scoreboard`: busy vector, set/clear/check, and error detection.
- The arbiter and starvation counter live in the top module.

## Test plan
- Reset, then `req0Valid=1, req0Sel=5, req0Data=0xDEADBEEF` -> `req0Ready=1`, `writeEn=1`, `writeRegSel=5`, `writeData=0xDEADBEEF` in the same cycle.
- `req0Valid` and `req1Valid` held high with `STARVE_LIMIT=4`:
  - `req0` is granted for cycles 0–3 and `req1` on cycle 4;
  - the counter then returns to 0.
- `issueEn, issueSel=7`; next cycle `chk1Sel=7` -> `chk1Busy=1`; `req1` writes x7 -> `chk1Busy=0` the following cycle, `err=0`.
- `req1Sel=0` granted -> `req1Ready=1`, `writeEn=0`.
- `issueEn` on x3 and `req1` granted for x3 in the same cycle (x3 busy) -> `busy[3]` stays 1, `err=0`.
- Error and reset mid-operation:
  - `issueEn` on x9 twice without a clear -> `err=1` and it holds;
  - assert `rst` with x9 busy and `req1` pending -> `err=0`, `busy=0`, `req1Ready=0` during reset.
